// File: rtl/decoder_pkg.sv
// Shared types and constants for the N-to-2^N decoder with auto-scan.
package decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIRECT,
        ST_SCAN,
        ST_GAP
    } dec_state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mod_tick_counter.sv
// Free-running rate counter: pulses tick when the count reaches max, then restarts at 0.
// clr forces the count to 0; hold freezes it and suppresses tick.
module mod_tick_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         hold,
    input  logic [W-1:0] max,
    output logic         tick
);

    logic [W-1:0] cnt_q, cnt_d;

    // >= rather than == so a max lowered below the current count fires on the next compare
    assign tick = !clr && !hold && (cnt_q >= max);

    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_n_scan.sv
// Registered N-to-2^N one-hot decoder with enable, direct addressing and an auto-scan sequencer.
// Optional macro SCAN_DEADTIME_EN inserts one blanking cycle (ST_GAP) after every scan step.
module decoder_n_scan
    import decoder_pkg::*;
#(
    parameter int unsigned N          = 2,
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic [N-1:0]          a,
    input  logic [PRESCALE_W-1:0] tick_div,
    output logic [2**N-1:0]       bcode,
    output logic [N-1:0]          idx,
    output logic                  wrap
);

    localparam int unsigned OUTS = 2**N;
    localparam logic [OUTS-1:0] ONE_HOT0 = OUTS'(1);

    dec_state_t             state_q, state_d;
    logic [N-1:0]           idx_q, idx_d, idx_inc;
    logic [OUTS-1:0]        bcode_q, bcode_d;
    logic                   wrap_q, wrap_d;
    logic                   in_scan, scan_active, tick;
    logic [PRESCALE_W-1:0]  cnt_max;

    assign in_scan     = (state_q == ST_SCAN) || (state_q == ST_GAP);
    assign scan_active = en && (mode == MODE_SCAN) && in_scan;
    assign cnt_max     = (tick_div == '0) ? '0 : tick_div - PRESCALE_W'(1);
    assign idx_inc     = idx_q + N'(1);

    mod_tick_counter #(
        .W (PRESCALE_W)
    ) u_tick_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!scan_active),
        .hold  (state_q == ST_GAP),
        .max   (cnt_max),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        bcode_d = bcode_q;
        wrap_d  = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            bcode_d = '0;
        end else if (mode == MODE_DIRECT) begin
            state_d = ST_DIRECT;
            idx_d   = a;
            bcode_d = ONE_HOT0 << a;
        end else if (!in_scan) begin
            // Fresh entry into scan always restarts at line 0 without a wrap pulse
            state_d = ST_SCAN;
            idx_d   = '0;
            bcode_d = ONE_HOT0;
        end else if (state_q == ST_GAP) begin
            state_d = ST_SCAN;
            bcode_d = ONE_HOT0 << idx_q;
        end else if (tick) begin
            idx_d  = idx_inc;
            wrap_d = (idx_inc == '0);
`ifdef SCAN_DEADTIME_EN
            state_d = ST_GAP;
            bcode_d = '0;
`else
            bcode_d = ONE_HOT0 << idx_inc;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            bcode_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            bcode_q <= bcode_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bcode = bcode_q;
    assign idx   = idx_q;
    assign wrap  = wrap_q;

`ifndef SYNTHESIS
    bcode_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bcode_q));
`endif

endmodule

// File: tb/tb_decoder_n_scan.sv
// Scoreboard bench for decoder_n_scan: drives directed vectors into an N=2 and an N=3 instance,
// queues hand-computed expectations, and a monitor checks them on the falling edge.
module tb_decoder_n_scan;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        mode = 1'b0;
    logic [1:0]  a = 2'd0;
    logic [2:0]  a3;
    logic [15:0] tick_div = 16'd3;
    logic [3:0]  bcode2;
    logic [1:0]  idx2;
    logic        wrap2;
    logic [7:0]  bcode3;
    logic [2:0]  idx3;
    logic        wrap3;

    int          cyc = 0;
    int          n_vec = 0;
    int          n_miss = 0;
    int          chk_kind = 0;
    event        side_chk;

    typedef struct {
        int         cyc;
        bit         d3;
        logic [7:0] bcode;
        logic [2:0] idx;
        logic       wrap;
        string      name;
    } exp_t;

    exp_t q[$];
    logic [3:0] oh[4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    assign a3 = {1'b0, a};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    decoder_n_scan #(.N(2), .PRESCALE_W(16)) u_dut2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .a        (a),
        .tick_div (tick_div),
        .bcode    (bcode2),
        .idx      (idx2),
        .wrap     (wrap2)
    );

    decoder_n_scan #(.N(3), .PRESCALE_W(16)) u_dut3 (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .a        (a3),
        .tick_div (tick_div),
        .bcode    (bcode3),
        .idx      (idx3),
        .wrap     (wrap3)
    );

    // Monitor: pops expectations due this cycle; side_chk requests async-reset or drain checks
    initial begin
        exp_t       e;
        logic [7:0] ab;
        logic [2:0] ai;
        logic       aw;
        forever begin
            @(negedge clk or side_chk);
            if (chk_kind == 1) begin
                n_vec++;
                if (bcode2 != 4'd0 || idx2 != 2'd0 || wrap2 || bcode3 != 8'd0 || idx3 != 3'd0 || wrap3)
                begin
                    n_miss++;
                    $display("FAIL reset_zero: got %b/%0d/%b %b/%0d/%b, want all zero",
                             bcode2, idx2, wrap2, bcode3, idx3, wrap3);
                end
            end else if (chk_kind == 2) begin
                n_vec++;
                if (q.size() != 0) begin
                    n_miss++;
                    $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
                end
            end else begin
                while (q.size() > 0 && q[0].cyc <= cyc) begin
                    e  = q.pop_front();
                    ab = e.d3 ? bcode3 : {4'b0000, bcode2};
                    ai = e.d3 ? idx3 : {1'b0, idx2};
                    aw = e.d3 ? wrap3 : wrap2;
                    n_vec++;
                    if (e.cyc != cyc || ab != e.bcode || ai != e.idx || aw != e.wrap) begin
                        n_miss++;
                        $display("FAIL %s cyc=%0d: got bcode=%b idx=%0d wrap=%b, want bcode=%b idx=%0d wrap=%b (due cyc %0d)",
                                 e.name, cyc, ab, ai, aw, e.bcode, e.idx, e.wrap, e.cyc);
                    end
                end
            end
        end
    end

    task automatic drive(input logic e, input logic m, input logic [1:0] aa, input logic [15:0] td);
        @(posedge clk);
        #1;
        en = e;
        mode = m;
        a = aa;
        tick_div = td;
    endtask

    task automatic push(input bit d3, input logic [7:0] b, input logic [2:0] i, input logic w,
                        input string nm);
        exp_t e;
        e = '{cyc + 1, d3, b, i, w, nm};
        q.push_back(e);
    endtask

    task automatic step(input logic e, input logic m, input logic [1:0] aa, input logic [15:0] td,
                        input logic [3:0] b, input logic [1:0] i, input logic w, input string nm);
        drive(e, m, aa, td);
        push(1'b0, {4'b0000, b}, {1'b0, i}, w, nm);
    endtask

    // Fresh scan entry held for len cycles; expectations for both the 4-line and 8-line instance
    task automatic scan_run(input logic [15:0] td, input int len, input string nm);
        int p;
        p = (td == 16'd0) ? 1 : int'(td);
        for (int c = 0; c < len; c++) begin
            int s, k, i2, i3;
            logic [7:0] b2, b3;
            logic w2, w3;
`ifdef SCAN_DEADTIME_EN
            s = c / (p + 1);
            k = c % (p + 1);
            if (k < p) begin
                i2 = s % 4; i3 = s % 8;
                b2 = 8'd1 << i2; b3 = 8'd1 << i3;
                w2 = 1'b0; w3 = 1'b0;
            end else begin
                i2 = (s + 1) % 4; i3 = (s + 1) % 8;
                b2 = 8'd0; b3 = 8'd0;
                w2 = (i2 == 0); w3 = (i3 == 0);
            end
`else
            s = c / p;
            k = c % p;
            i2 = s % 4; i3 = s % 8;
            b2 = 8'd1 << i2; b3 = 8'd1 << i3;
            w2 = (k == 0) && (s > 0) && (i2 == 0);
            w3 = (k == 0) && (s > 0) && (i3 == 0);
`endif
            drive(1'b1, 1'b1, 2'd0, td);
            push(1'b0, b2, 3'(i2), w2, nm);
            push(1'b1, b3, 3'(i3), w3, {nm, "_n3"});
        end
    endtask

    initial begin
        #12;
        chk_kind = 1;
        -> side_chk;
        @(negedge clk);
        rst_n = 1'b1;
        chk_kind = 0;

        // Direct decode, each address held 4 cycles
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 4; r++)
                step(1'b1, 1'b0, 2'(i), 16'd3, oh[i], 2'(i), 1'b0, "direct");

        // Disable with every address and both modes, then en falling mid-stream
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 2'(i), 16'd3, 4'b0000, 2'd0, 1'b0, "dis_direct");
            step(1'b0, 1'b1, 2'(i), 16'd3, 4'b0000, 2'd0, 1'b0, "dis_scan");
        end
        step(1'b1, 1'b0, 2'd3, 16'd3, 4'b1000, 2'd3, 1'b0, "pre_fall");
        step(1'b0, 1'b0, 2'd3, 16'd3, 4'b0000, 2'd0, 1'b0, "en_fall");
        step(1'b1, 1'b0, 2'd1, 16'd3, 4'b0010, 2'd1, 1'b0, "pre_fall2");
        step(1'b0, 1'b1, 2'd1, 16'd3, 4'b0000, 2'd0, 1'b0, "en_wins");

        // Scan rates
        scan_run(16'd3, 27, "scan3");
        step(1'b0, 1'b1, 2'd0, 16'd0, 4'b0000, 2'd0, 1'b0, "idle");
        scan_run(16'd0, 10, "scan0");
        step(1'b0, 1'b1, 2'd0, 16'd1, 4'b0000, 2'd0, 1'b0, "idle");
        scan_run(16'd1, 10, "scan1");
        step(1'b0, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd0, 1'b0, "idle");
        scan_run(16'd2, 12, "scan2");
        step(1'b0, 1'b1, 2'd0, 16'd10, 4'b0000, 2'd0, 1'b0, "idle");

        // Rate lowered 10->2 while cnt=5, then SCAN->DIRECT->SCAN
        scan_run(16'd10, 6, "pre_rate");
`ifdef SCAN_DEADTIME_EN
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd1, 1'b0, "rate_chg");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0, "rate_a");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0, "rate_b");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0000, 2'd2, 1'b0, "rate_c");
`else
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0, "rate_chg");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0010, 2'd1, 1'b0, "rate_a");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0100, 2'd2, 1'b0, "rate_b");
        step(1'b1, 1'b1, 2'd0, 16'd2, 4'b0100, 2'd2, 1'b0, "rate_c");
`endif
        step(1'b1, 1'b0, 2'd2, 16'd2, 4'b0100, 2'd2, 1'b0, "to_direct");
        scan_run(16'd2, 4, "rescan");
        step(1'b1, 1'b0, 2'd0, 16'd3, 4'b0001, 2'd0, 1'b0, "direct2");

        // Asynchronous reset in the middle of a scan
        scan_run(16'd3, 5, "pre_rst");
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_kind = 1;
        -> side_chk;
        @(posedge clk);
        #1;
        chk_kind = 0;
        @(negedge clk);
        rst_n = 1'b1;
        push(1'b0, 8'b0001, 3'd0, 1'b0, "rst_entry");
        push(1'b1, 8'b0001, 3'd0, 1'b0, "rst_entry_n3");
        step(1'b1, 1'b1, 2'd0, 16'd3, 4'b0001, 2'd0, 1'b0, "rst_hold1");
        step(1'b1, 1'b1, 2'd0, 16'd3, 4'b0001, 2'd0, 1'b0, "rst_hold2");

        repeat (3) @(posedge clk);
        #2;
        chk_kind = 2;
        -> side_chk;
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
